// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - 8N1 UART receive front-end: synchroniser, majority filter, framer, holding register
module uart_rx_deser #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);

   // The IDLE detection cycle makes cnt lag the line by one, so the three-sample
   // window sits at cnt = H-2, H-1, H with the decision taken at cnt = H.
   localparam logic [CW-1:0] C_SAMP0 = CW'(H - 2);
   localparam logic [CW-1:0] C_SAMP1 = CW'(H - 1);
   localparam logic [CW-1:0] C_DEC   = CW'(H);
   localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_sync1;
   logic            r_sync2;
   logic [CW-1:0]   r_cnt;
   logic [3:0]      r_bi;
   logic [1:0]      r_samp;
   logic [7:0]      r_shift;
   logic            w_dec;
   logic            w_last;
   logic            w_maj;
   logic            w_deliver;
   logic            w_ferr;

   assign w_dec  = (r_cnt == C_DEC);
   assign w_last = (r_cnt == C_LAST);
   assign w_maj  = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_sync2) | (r_samp[1] & r_sync2);
   assign busy   = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx_in;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_deliver   = 1'b0;
      w_ferr      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!r_sync2) w_state_nxt = S_START;
         end
         S_START: begin
            if (w_dec && w_maj)  w_state_nxt = S_IDLE;
            else if (w_last)     w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (w_last && (r_bi == 4'd8)) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            if (w_dec) begin
               if (w_maj) begin
                  w_deliver   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_ferr      = 1'b1;
                  w_state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (r_sync2) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_bi      <= '0;
         r_samp    <= 2'b11;
         r_shift   <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) || (w_state_nxt != r_state) || w_last) r_cnt <= '0;
         else                                                             r_cnt <= r_cnt + 1'b1;

         if (r_state == S_IDLE)
            r_bi <= '0;
         else if (w_last && ((r_state == S_START) || (r_state == S_DATA)))
            r_bi <= r_bi + 1'b1;

         if (r_cnt == C_SAMP0) r_samp[0] <= r_sync2;
         if (r_cnt == C_SAMP1) r_samp[1] <= r_sync2;

         if ((r_state == S_DATA) && w_dec) r_shift <= {w_maj, r_shift[7:1]};

         frame_err <= w_ferr;
         overrun   <= w_deliver & rx_valid & ~rx_ready;

         if (w_deliver && (!rx_valid || rx_ready)) begin
            rx_data  <= r_shift;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb/tb_uart_rx_deser.sv - directed bench with a frame-level scoreboard for uart_rx_deser
module tb_uart_rx_deser;

   localparam int CPB = 16;
   localparam int H   = CPB / 2;
   localparam int DEC = 9 * CPB + H + 3;
   localparam int BIG = 32'h7fff_ffff;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b0;
   logic       rx_in    = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   uart_rx_deser #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx_in     (rx_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         t;
      bit         ferr;
      logic [7:0] d;
   } ev_s;

   ev_s        evq[$];
   int         bs[$];
   int         be[$];
   int         cyc = 0;
   logic       rdy_s = 1'b0;
   int         n_cmp = 0;
   int         n_fail = 0;
   logic       exp_valid = 1'b0;
   logic [7:0] exp_data = 8'h00;
   logic       exp_ferr;
   logic       exp_ovr;
   logic       exp_busy;
   bit         dlv;
   logic       prev_valid = 1'b0;
   int         rise_cyc = -1;
   int         rise_cnt = 0;
   int         ferr_cyc = -1;
   int         ferr_cnt = 0;
   int         ovr_cyc  = -1;
   int         ovr_cnt  = 0;
   int         busy_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      cyc   = cyc + 1;
      rdy_s = rx_ready;
   end

   // Frame-level model: each sent frame schedules its outcome at its stop decision edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         evq.delete();
         bs.delete();
         be.delete();
         exp_valid  = 1'b0;
         exp_data   = 8'h00;
         prev_valid = 1'b0;
      end else begin
         exp_ferr = 1'b0;
         exp_ovr  = 1'b0;
         dlv      = 1'b0;
         while (evq.size() > 0 && evq[0].t < cyc) begin
            chk("event_time", cyc, evq[0].t);
            void'(evq.pop_front());
         end
         if (evq.size() > 0 && evq[0].t == cyc) begin
            if (evq[0].ferr) begin
               exp_ferr = 1'b1;
            end else begin
               dlv = 1'b1;
               if (!exp_valid || rdy_s) begin
                  exp_valid = 1'b1;
                  exp_data  = evq[0].d;
               end else begin
                  exp_ovr = 1'b1;
               end
            end
            void'(evq.pop_front());
         end
         if (!dlv && exp_valid && rdy_s) exp_valid = 1'b0;
         exp_busy = 1'b0;
         foreach (bs[i]) if (bs[i] <= cyc && cyc < be[i]) exp_busy = 1'b1;

         chk("rx_valid",  rx_valid,  exp_valid);
         chk("rx_data",   rx_data,   exp_data);
         chk("frame_err", frame_err, exp_ferr);
         chk("overrun",   overrun,   exp_ovr);
         chk("busy",      busy,      exp_busy);

         if (rx_valid && !prev_valid) begin
            rise_cyc = cyc;
            rise_cnt = rise_cnt + 1;
         end
         prev_valid = rx_valid;
         if (frame_err) begin
            ferr_cyc = cyc;
            ferr_cnt = ferr_cnt + 1;
         end
         if (overrun) begin
            ovr_cyc = cyc;
            ovr_cnt = ovr_cnt + 1;
         end
         if (busy) busy_cnt = busy_cnt + 1;
      end
   end

   task automatic send_frame(input logic [7:0] d, input logic stop, input bit glitch, output int e0);
      logic v;
      ev_s  ev;
      e0      = cyc + 1;
      ev.t    = e0 + DEC;
      ev.ferr = ~stop;
      ev.d    = d;
      evq.push_back(ev);
      bs.push_back(e0 + 2);
      be.push_back(stop ? e0 + DEC : BIG);
      for (int b = 0; b < 10; b++) begin
         v = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
         rx_in = v;
         if (glitch && b >= 1 && b <= 8) begin
            repeat (H) tick();
            rx_in = ~v;
            tick();
            rx_in = v;
            repeat (CPB - H - 1) tick();
         end else begin
            repeat (CPB) tick();
         end
      end
   endtask

   task automatic consume();
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0;
      int e0b;
      int dec2;

      repeat (3) tick();
      chk("reset_rx_data",   rx_data,   8'h00);
      chk("reset_rx_valid",  rx_valid,  1'b0);
      chk("reset_frame_err", frame_err, 1'b0);
      chk("reset_overrun",   overrun,   1'b0);
      chk("reset_busy",      busy,      1'b0);
      reset_n = 1'b1;
      repeat (4) tick();

      rise_cyc = -1;
      send_frame(8'hA5, 1'b1, 1'b0, e0);
      chk("a5_latency", rise_cyc - e0, 155);
      chk("a5_data",    rx_data,  8'hA5);
      chk("a5_valid",   rx_valid, 1'b1);
      repeat (3) tick();
      consume();
      chk("a5_accepted", rx_valid, 1'b0);

      ferr_cnt = 0;
      rise_cnt = 0;
      send_frame(8'h3C, 1'b0, 1'b0, e0);
      chk("ferr_count",   ferr_cnt, 1);
      chk("ferr_latency", ferr_cyc - e0, 155);
      chk("ferr_no_data", rise_cnt, 0);
      repeat (100) tick();
      chk("break_busy", busy, 1'b1);
      rx_in = 1'b1;
      be[be.size() - 1] = cyc + 3;
      repeat (20) tick();
      chk("break_exit", busy, 1'b0);
      chk("break_ferr_count", ferr_cnt, 1);
      send_frame(8'h55, 1'b1, 1'b0, e0);
      chk("after_break_data", rx_data, 8'h55);
      consume();

      rise_cnt = 0;
      ferr_cnt = 0;
      ovr_cnt  = 0;
      busy_cnt = 0;
      e0 = cyc + 1;
      bs.push_back(e0 + 2);
      be.push_back(e0 + H + 3);
      rx_in = 1'b0;
      repeat (3) tick();
      rx_in = 1'b1;
      repeat (30) tick();
      chk("false_start_busy_cycles", busy_cnt, 9);
      chk("false_start_valid", rise_cnt, 0);
      chk("false_start_ferr",  ferr_cnt, 0);
      chk("false_start_ovr",   ovr_cnt,  0);

      ovr_cnt = 0;
      send_frame(8'h11, 1'b1, 1'b0, e0);
      send_frame(8'h22, 1'b1, 1'b0, e0b);
      chk("ovr_count",   ovr_cnt, 1);
      chk("ovr_latency", ovr_cyc - e0b, 155);
      chk("ovr_data",    rx_data, 8'h11);
      chk("ovr_valid",   rx_valid, 1'b1);
      consume();
      chk("ovr_drained", rx_valid, 1'b0);

      ovr_cnt = 0;
      send_frame(8'h11, 1'b1, 1'b0, e0);
      e0b  = cyc + 1;
      dec2 = e0b + DEC;
      fork
         send_frame(8'h22, 1'b1, 1'b0, e0b);
         begin
            while (cyc < dec2 - 1) tick();
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
         end
      join
      chk("swap_ovr",   ovr_cnt, 0);
      chk("swap_data",  rx_data, 8'h22);
      chk("swap_valid", rx_valid, 1'b1);
      consume();

      send_frame(8'h0F, 1'b1, 1'b1, e0);
      chk("glitch_data",  rx_data, 8'h0F);
      chk("glitch_valid", rx_valid, 1'b1);

      e0 = cyc + 1;
      bs.push_back(e0 + 2);
      be.push_back(BIG);
      rx_in = 1'b0;
      repeat (CPB) tick();
      rx_in = 1'b1;
      repeat (4 * CPB + H) tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("midreset_rx_data",   rx_data,   8'h00);
      chk("midreset_rx_valid",  rx_valid,  1'b0);
      chk("midreset_frame_err", frame_err, 1'b0);
      chk("midreset_overrun",   overrun,   1'b0);
      chk("midreset_busy",      busy,      1'b0);
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (5) tick();
      rise_cyc = -1;
      send_frame(8'h81, 1'b1, 1'b0, e0);
      chk("r81_latency", rise_cyc - e0, 155);
      chk("r81_data",    rx_data, 8'h81);
      repeat (5) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Receive front-end that feeds the UART core. It takes the raw asynchronous serial line from an input pin, synchronises and majority-filters it, and frames 8N1 characters at a fixed clocks-per-bit rate. Each completed byte is presented to the core through a single-entry valid/ready holding register, with framing-error and overrun pulses.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be even and ≥ 4.
- `H`, default `CLKS_PER_BIT/2`: derived local parameter, not overridable; mid-bit sample point.

Ports:
- `clk` in 1: single clock; all state is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset; deassertion is already synchronised upstream.
- `rx_in` in 1: raw serial line, asynchronous to `clk`, idle high.
- `rx_data` out 8: received byte, valid while `rx_valid`=1.
- `rx_valid` out 1: holding register full.
- `rx_ready` in 1: consumer accepts `rx_data` at an edge where `rx_valid`=1 and `rx_ready`=1.
- `frame_err` out 1: one-cycle pulse when the stop bit samples low.
- `overrun` out 1: one-cycle pulse when a completed byte is dropped.
- `busy` out 1: high in any state other than IDLE.

## Operation

- Synchroniser: 2 flops, `sync1` then `sync2`. Both reset to 1. All logic uses `sync2` only.
- Bit counter `cnt`: counts 0..`CLKS_PER_BIT`-1 and wraps to 0. Bit index `bi` counts 0..9: 0 is the start bit, 1..8 are data LSB first, 9 is the stop bit.
- Majority sampling: capture `sync2` at the edges where `cnt` = H-1, H and H+1. The bit value is the majority of the three, decided at the `cnt`=H+1 edge.
- States:
  - IDLE: on `sync2`=0, go to START with `cnt`←0 and `bi`←0.
  - START: at the decision edge, majority 1 means a false start, so go to IDLE with no output. Majority 0 means continue. At `cnt`=`CLKS_PER_BIT`-1, go to DATA with `bi`←1.
  - DATA: at each decision edge, shift the majority into the shift register from the MSB side (LSB arrives first). After `bi`=8 wraps, go to STOP.
  - STOP: the decision edge is the final edge of the frame.
    - Majority 1: deliver the byte and go to IDLE.
    - Majority 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `sync2`=1, then go to IDLE. This stops a held-low line from generating repeated frames.
- Because the frame ends at the stop-bit decision edge, a new start bit may be detected from mid-stop onward.
- Delivery at the stop decision edge:
  - `rx_valid`=0: load `rx_data`, set `rx_valid`.
  - `rx_valid`=1 and `rx_ready`=1 at the same edge: load the new byte; `rx_valid` stays 1.
  - `rx_valid`=1 and `rx_ready`=0: keep the old byte, drop the new one, pulse `overrun`.
- Accept: `rx_valid`=1 and `rx_ready`=1 with no delivery at that edge clears `rx_valid`. `rx_data` holds its last value.
- `frame_err` and `overrun` are never asserted at the same edge.

## Timing

- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0. State is IDLE, `cnt`=0, `bi`=0, synchroniser flops=1.
- Reset mid-frame: immediate return to reset values. The partial byte is lost and there are no pulses.
- Latency: let E0 be the first edge at which `sync1` captures a low `rx_in`.
  - START is entered at E2.
  - The stop decision is at E(9·`CLKS_PER_BIT`+H+3). With defaults that is E155.
  - `rx_valid`, `frame_err` and `overrun` are registered and visible after that edge.
- Pulses last exactly one cycle. `busy` rises after E2 and falls after the stop decision edge, or after leaving BREAK.
- A single-cycle glitch on `rx_in` at a sample point cannot flip a bit value.
- A low lasting fewer than H-1 cycles before the start decision window is rejected as a false start.

## Test plan

- Send 0xA5 with defaults, `rx_ready`=0 → `rx_valid` rises after E155 with `rx_data`=0xA5. Raise `rx_ready` for one cycle → `rx_valid`=0.
- Send 0x3C with stop bit driven low → `frame_err` pulses once at the stop decision edge and `rx_valid` stays 0. Hold `rx_in` low 100 cycles, then high, then send 0x55 → `rx_data`=0x55.
- Drive a 3-cycle low pulse on idle `rx_in` → `busy` pulses, and there is no `rx_valid`, `frame_err` or `overrun`.
- Send 0x11 then 0x22 back-to-back with `rx_ready`=0 → `rx_data`=0x11 and `overrun` pulses once. Repeat with `rx_ready`=1 exactly at the second delivery edge → `rx_data`=0x22, `rx_valid` stays 1, no `overrun`.
- Inject a 1-cycle inverted glitch at `cnt`=H of every data bit while sending 0x0F → `rx_data`=0x0F.
- Assert `reset_n`=0 mid-way through data bit 4 of 0xFF → all outputs 0 immediately. Release, send 0x81 → `rx_data`=0x81 with correct latency.
